// File: rtl/game_physics_engine.sv
// Per-frame dino game state: jump physics, two scrolling obstacles, collision, score, IDLE/RUNNING/OVER FSM.
// Outputs are registered and change only on the clk after a frameClk pulse; no backpressure, every pulse is consumed.
module game_physics_engine #(
  parameter int unsigned X_MAX     = 159,
  parameter int unsigned GROUND_Y  = 100,
  parameter int unsigned DINO_X    = 20,
  parameter int unsigned DINO_W    = 10,
  parameter int unsigned DINO_H    = 12,
  parameter int unsigned JUMP_V0   = 8,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned OBS_W     = 6,
  parameter int unsigned SCROLL    = 2,
  parameter int unsigned OBS_GAP   = 80,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frameClk,
  input  logic        jump,
  output logic [3:0]  gameState,
  output logic [7:0]  dinoY,
  output logic [7:0]  obs1X,
  output logic [7:0]  obs1H,
  output logic [7:0]  obs2X,
  output logic [7:0]  obs2H,
  output logic [15:0] score
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RUNNING = 4'd1,
    ST_OVER    = 4'd2
  } state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] h;
  } obs_t;

  localparam logic [7:0]        X_MAX_B  = 8'(X_MAX);
  localparam logic [7:0]        SCROLL_B = 8'(SCROLL);
  localparam logic [7:0]        REST_Y   = 8'(GROUND_Y - DINO_H);
  localparam logic signed [8:0] REST_Y_S = 9'(GROUND_Y - DINO_H);
  localparam logic signed [8:0] JUMP_V   = 9'(JUMP_V0);
  localparam logic signed [8:0] GRAV     = 9'(GRAVITY);
  localparam logic [9:0]        DX_LO    = 10'(DINO_X);
  localparam logic [9:0]        DX_HI    = 10'(DINO_X + DINO_W - 1);
  localparam logic [9:0]        OW_M1    = 10'(OBS_W - 1);
  localparam logic [9:0]        DH_M1    = 10'(DINO_H - 1);
  localparam logic [9:0]        GY       = 10'(GROUND_Y);
  localparam obs_t              OBS1_RST = '{x: X_MAX_B, h: 8'd8};
  localparam obs_t              OBS2_RST = '{x: 8'(X_MAX + OBS_GAP), h: 8'd10};

  state_e            state_q, state_d;
  logic [7:0]        dino_y_q, dino_y_d;
  logic signed [8:0] vy_q, vy_d;
  obs_t              obs1_q, obs1_d, obs2_q, obs2_d;
  logic [15:0]       score_q, score_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              jump_req_q, jump_req_d;
  logic              jump_prev_q, jump_prev_d;

  logic              jump_now;
  logic signed [8:0] vy_eff;
  logic signed [8:0] y_next;
  obs_t              obs1_n, obs2_n;

  // Respawn is decided on the pre-step column so the subtraction never wraps.
  function automatic obs_t obs_step(input obs_t o, input logic [2:0] rnd);
    obs_t n;
    if (o.x < SCROLL_B) begin
      n.x = X_MAX_B;
      n.h = 8'd6 + {5'd0, rnd};
    end else begin
      n.x = o.x - SCROLL_B;
      n.h = o.h;
    end
    return n;
  endfunction

  // Y overlap rearranged as dy+DINO_H-1+h >= GROUND_Y to avoid an unsigned underflow.
  function automatic logic obs_hit(input logic [7:0] dy, input obs_t o);
    logic [9:0] ox;
    logic [9:0] oy;
    logic [9:0] oh;
    ox = {2'b00, o.x};
    oy = {2'b00, dy};
    oh = {2'b00, o.h};
    return (o.x <= X_MAX_B) && (ox <= DX_HI) && (ox + OW_M1 >= DX_LO) &&
           (oy <= GY - 10'd1) && (oy + DH_M1 + oh >= GY);
  endfunction

  always_comb begin
    jump_prev_d = jump;
    jump_now    = jump_req_q | (jump & ~jump_prev_q);
    jump_req_d  = frameClk ? 1'b0 : jump_now;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    state_d  = state_q;
    dino_y_d = dino_y_q;
    vy_d     = vy_q;
    obs1_d   = obs1_q;
    obs2_d   = obs2_q;
    score_d  = score_q;
    vy_eff   = vy_q;
    y_next   = '0;
    obs1_n   = obs_step(obs1_q, lfsr_q[2:0]);
    obs2_n   = obs_step(obs2_q, lfsr_q[2:0]);

    if (frameClk) begin
      case (state_q)
        ST_IDLE: begin
          if (jump_now) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (dino_y_q == REST_Y && vy_q == '0 && jump_now) vy_eff = -JUMP_V;
          y_next = $signed({1'b0, dino_y_q}) + vy_eff;
          if (y_next >= REST_Y_S) begin
            dino_y_d = REST_Y;
            vy_d     = '0;
          end else begin
            dino_y_d = y_next[7:0];
            vy_d     = vy_eff + GRAV;
          end
          obs1_d  = obs1_n;
          obs2_d  = obs2_n;
          score_d = (&score_q) ? score_q : score_q + 16'd1;
          if (obs_hit(dino_y_d, obs1_n) || obs_hit(dino_y_d, obs2_n)) state_d = ST_OVER;
        end
        ST_OVER: begin
          if (jump_now) begin
            state_d  = ST_IDLE;
            dino_y_d = REST_Y;
            vy_d     = '0;
            obs1_d   = OBS1_RST;
            obs2_d   = OBS2_RST;
            score_d  = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      dino_y_q    <= REST_Y;
      vy_q        <= '0;
      obs1_q      <= OBS1_RST;
      obs2_q      <= OBS2_RST;
      score_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      jump_req_q  <= 1'b0;
      jump_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dino_y_q    <= dino_y_d;
      vy_q        <= vy_d;
      obs1_q      <= obs1_d;
      obs2_q      <= obs2_d;
      score_q     <= score_d;
      lfsr_q      <= lfsr_d;
      jump_req_q  <= jump_req_d;
      jump_prev_q <= jump_prev_d;
    end
  end

  assign gameState = state_q;
  assign dinoY     = dino_y_q;
  assign obs1X     = obs1_q.x;
  assign obs1H     = obs1_q.h;
  assign obs2X     = obs2_q.x;
  assign obs2H     = obs2_q.h;
  assign score     = score_q;

endmodule
